// File: rtl/mem_bus_pkg.sv
// Shared constants and address-decode helper for the system memory bus.
package mem_bus_pkg;

  localparam logic [1:0] IO_REGION    = 2'b11;
  localparam int         IO_SEL_WIDTH = 3;
  localparam int         ADDR_MAX_W   = 64;

  // IO window is the two address bits at [ram_aw:ram_aw-1].
  function automatic logic is_io(input logic [ADDR_MAX_W-1:0] addr,
                                 input int unsigned           ram_aw);
    logic [ADDR_MAX_W-1:0] sh;
    sh = addr >> (ram_aw - 1);
    return (sh[1:0] == IO_REGION);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pointer with masked priority encoder; pointer moves past each winner unless held.
module rr_arbiter
  import mem_bus_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] elig,
  input  logic         hold,
  output logic [N-1:0] winner,
  output logic         valid
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_idx;

  always_comb begin
    int idx;
    idx     = 0;
    winner  = '0;
    valid   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!valid && elig[idx]) begin
        valid       = 1'b1;
        winner[idx] = 1'b1;
        win_idx     = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (valid && !hold) begin
      ptr <= (win_idx == PTR_W'(N - 1)) ? '0 : win_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master arbiter for the byte-wide memory bus: lock, debug override, IO decode and
// IO-full stall, with one-cycle read-data return to the previously granted master.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int PRIO_MASTER    = 0
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              prio_active,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_wr,
  input  logic [NUM_MASTERS-1:0]            m_lock,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*8-1:0]          m_dout,
  output logic [NUM_MASTERS-1:0]            m_gnt,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  output logic [7:0]                        m_rdata,
  output logic                              ram_en,
  output logic                              ram_r_nw,
  output logic [RAM_ADDR_WIDTH-1:0]         ram_a,
  output logic [7:0]                        ram_d_in,
  input  logic [7:0]                        ram_d_out,
  output logic                              io_en,
  output logic                              io_wr,
  output logic [IO_SEL_WIDTH-1:0]           io_sel,
  output logic [7:0]                        io_din,
  input  logic [7:0]                        io_dout,
  input  logic                              io_full
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] elig;
  logic [NUM_MASTERS-1:0] rr_gnt;
  logic [NUM_MASTERS-1:0] gnt;
  logic                   rr_valid;
  logic                   held;
  logic                   hold;
  logic                   gnt_any;
  logic [IDX_W-1:0]       w;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic                   sel_io;
  logic                   sel_wr;

  logic                   lock_valid;
  logic [IDX_W-1:0]       lock_owner;
  logic                   q_valid;
  logic                   q_is_io;
  logic [IDX_W-1:0]       q_owner;

  // An IO write is parked while the UART buffer is full; the debug override masks everyone else.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      elig[i] = m_req[i]
              & ~(m_wr[i] & io_full
                  & is_io(ADDR_MAX_W'(m_addr[i*ADDR_WIDTH +: ADDR_WIDTH]), RAM_ADDR_WIDTH))
              & (~prio_active | (i == PRIO_MASTER));
    end
    if (rst_in) elig = '0;
  end

  assign held = lock_valid & m_req[lock_owner] & m_lock[lock_owner] & ~prio_active;
  assign hold = held | prio_active;

  rr_arbiter #(
    .N (NUM_MASTERS)
  ) u_rr (
    .clk    (clk_in),
    .rst    (rst_in),
    .elig   (elig),
    .hold   (hold),
    .winner (rr_gnt),
    .valid  (rr_valid)
  );

  // A held lock owner that is stalled gets nothing, and nobody else is let in either.
  always_comb begin
    gnt = '0;
    if (held) gnt[lock_owner] = elig[lock_owner];
    else if (rr_valid) gnt = rr_gnt;
  end

  always_comb begin
    w = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt[i]) w = IDX_W'(i);
    end
  end

  assign gnt_any  = |gnt;
  assign sel_addr = m_addr[w*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wr   = m_wr[w];
  assign sel_io   = is_io(ADDR_MAX_W'(sel_addr), RAM_ADDR_WIDTH);

  assign m_gnt    = gnt;
  assign ram_en   = gnt_any & ~sel_io;
  assign io_en    = gnt_any & sel_io;
  assign ram_r_nw = gnt_any ? ~sel_wr : 1'b1;
  assign io_wr    = gnt_any & sel_wr;
  assign ram_a    = sel_addr[RAM_ADDR_WIDTH-1:0];
  assign io_sel   = sel_addr[IO_SEL_WIDTH-1:0];
  assign ram_d_in = m_dout[w*8 +: 8];
  assign io_din   = m_dout[w*8 +: 8];

  // Lock state is frozen under the debug override and kept while the owner still holds it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      lock_valid <= 1'b0;
      lock_owner <= '0;
    end else if (!prio_active && !held) begin
      lock_valid <= gnt_any & m_lock[w];
      if (gnt_any & m_lock[w]) lock_owner <= w;
    end
  end

  // ---- read-return stage ----
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      q_valid <= 1'b0;
      q_is_io <= 1'b0;
      q_owner <= '0;
    end else begin
      q_valid <= gnt_any & ~sel_wr;
      q_is_io <= sel_io;
      q_owner <= w;
    end
  end

  always_comb begin
    m_rvalid          = '0;
    m_rvalid[q_owner] = q_valid;
  end

  assign m_rdata = q_is_io ? io_dout : ram_d_out;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Parametrised N-master arbiter for the byte-wide system memory bus. It grants one requester per cycle onto the shared RAM/IO port, decodes the IO window, stalls IO writes while the UART buffer is full, and routes registered read data back to the master granted in the previous cycle. It sits between the cache/fetch/debug masters and the `ram` and `hci` blocks. It replaces the fixed two-way CPU/HCI mux in the top level.

## Interface
- `NUM_MASTERS`, 2: number of requesters, ≥1.
- `ADDR_WIDTH`, 32: master address width.
- `RAM_ADDR_WIDTH`, 17: RAM address width; IO window is `addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11`.
- `PRIO_MASTER`, 0: index of the debug master served exclusively while `prio_active`.

Ports:
- `clk_in`  in  1  system clock; one clock.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `prio_active`  in  1  debug override; only `PRIO_MASTER` is eligible.
- `m_req`  in  N  per-master request.
- `m_wr`  in  N  1=write, 0=read.
- `m_lock`  in  N  hold grant across consecutive beats (multi-byte access).
- `m_addr`  in  N*ADDR_WIDTH  packed addresses, master i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `m_dout`  in  N*8  packed write data.
- `m_gnt`  out  N  one-hot grant, same cycle as the accepted beat.
- `m_rvalid`  out  N  one-hot read-return strobe.
- `m_rdata`  out  8  read data, shared by all masters.
- `ram_en`, `ram_r_nw`  out  1  RAM enable and read/not-write.
- `ram_a`  out  RAM_ADDR_WIDTH;  `ram_d_in`  out  8;  `ram_d_out`  in  8.
- `io_en`, `io_wr`  out  1;  `io_sel`  out  3 (`addr[2:0]`);  `io_din`  out  8;  `io_dout`  in  8;  `io_full`  in  1.

## Operation
- Eligibility: `m_req[i]` set. When `prio_active` is set, only `i==PRIO_MASTER` is eligible. A master is ineligible in any cycle where it requests an IO write while `io_full` is set.
- Lock: if `lock_valid` is set and the owner is eligible with `m_lock` set, the owner wins.
  - If the owner drops `m_req` or `m_lock`, the lock clears and normal round-robin runs in that same cycle.
  - An owner blocked by `io_full` keeps the lock and receives no grant. No other master is granted.
- Round-robin: the winner is the first eligible index at or after `rr_ptr`, wrapping modulo N. On a grant, `rr_ptr <= winner+1` (mod N). `rr_ptr` does not advance on a lock-held grant.
- Lock capture: a grant with `m_lock` set loads `lock_owner <= winner` and `lock_valid <= 1`.
- `prio_active` freezes `lock_valid`, `lock_owner` and `rr_ptr`. The lock resumes when `prio_active` falls.
- Decode of the granted beat:
  - IO beat: `io_en=1`, `ram_en=0`.
  - RAM beat: `ram_en=1`, `io_en=0`.
  - `ram_r_nw=~m_wr[w]`, `io_wr=m_wr[w]`. Data and address come from the winner.
- No grant: `ram_en=0`, `io_en=0`, `io_wr=0`, `ram_r_nw=1`. Address and data outputs are don't-care.
- Read return:
  - A granted read registers `q_owner`, `q_is_io` and `q_valid`.
  - On the next cycle, `m_rvalid[q_owner]=q_valid`.
  - `m_rdata = q_is_io ? io_dout : ram_d_out`.
  - Writes never produce `m_rvalid`.

## Timing
- Grant and bus outputs are combinational from inputs plus registered state; zero-cycle issue.
- Read latency is exactly 1 cycle from grant to `m_rvalid`. Back-to-back reads from different masters pipeline at one per cycle.
- Reset (asynchronous): `rr_ptr=0`, `lock_valid=0`, `lock_owner=0`, `q_valid=0`, `q_is_io=0`, `q_owner=0`. Hence `m_rvalid=0` and `m_gnt=0` while reset is asserted.
- Reset mid-read: the pending return is dropped; no `m_rvalid` follows.
- `prio_active` asserted the cycle after a read grant: the return is still delivered to its original owner.
- `NUM_MASTERS==1`: `rr_ptr` is constant 0; lock and IO-full rules still apply.

## Structure
- Package `mem_bus_pkg`:
  - `IO_REGION = 2'b11`.
  - `IO_SEL_WIDTH = 3`.
  - Function `is_io(addr)` parametrised by `RAM_ADDR_WIDTH`.
- Sub-module `rr_arbiter`: `rr_ptr` register plus masked priority encoder. Inputs are the eligibility vector and a hold flag; outputs are the one-hot winner and a valid flag. The lock, priority override and read-return logic stay in the parent.

## Test plan
- N=3, all read RAM continuously from reset → grants 0,1,2,0,…; each `m_rvalid` one cycle later with matching `ram_d_out`.
- Master 1 locks a 4-byte write at 0x100–0x103 while 0 and 2 request → four consecutive `m_gnt[1]`, then grant 2 (`rr_ptr=2`).
- Master 0 writes IO 0x30004 with `io_full=1` for 5 cycles while master 1 reads RAM → master 1 served every cycle; master 0 granted on the first cycle `io_full=0`, with `io_wr=1`, `io_sel=4`.
- Read IO 0x30000 then RAM 0x10 back-to-back → first return carries `io_dout`, second carries `ram_d_out`.
- `prio_active=1` during master 2's lock → only `PRIO_MASTER` (0) granted; after release master 2 resumes with the lock intact.
- `rst_in` pulsed the cycle after a read grant → no `m_rvalid`; the next grant goes to master 0.
